// File: rtl/cmplx_pkg.sv
// Shared complex-number types and word/tag sizing for the multiplier arbiter.
package cmplx_pkg;

    localparam int unsigned WORD_SIZE = 8;
    localparam int unsigned WORD_W    = WORD_SIZE;
    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned IDX_W     = $clog2(MAX_REQ);

    typedef struct packed {
        logic signed [WORD_W-1:0] re;
        logic signed [WORD_W-1:0] im;
    } cmplx_t;

    // Ownership record travelling alongside each in-flight multiply.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/cmult_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner; owns the rotation pointer.
module rr_arbiter
    import cmplx_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               update_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic             found;
    int unsigned      cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        if (!reset) begin
            for (int unsigned off = 1; off <= NUM_REQ; off++) begin
                cand = (32'(ptr_q) + off) % NUM_REQ;
                if (!found && req_i[cand]) begin
                    found         = 1'b1;
                    grant_o[cand] = 1'b1;
                    grant_idx_o   = IDX_W'(cand);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else if (update_i) begin
            ptr_q <= grant_idx_o;
        end
    end

endmodule

// File: rtl/cmult_arbiter.sv
// Shares one pipelined complex multiplier between NUM_REQ requesters; a tag pipe
// matched to the core latency routes each result back to the requester that issued it.
module cmult_arbiter
    import cmplx_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned W        = WORD_W,
    parameter int unsigned MULT_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_re_a,
    input  logic [NUM_REQ*W-1:0] req_im_a,
    input  logic [NUM_REQ*W-1:0] req_re_q,
    input  logic [NUM_REQ*W-1:0] req_im_q,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [W-1:0]         rsp_re,
    output logic [W-1:0]         rsp_im,
    output logic                 m_in_valid,
    output logic [W-1:0]         m_re_a,
    output logic [W-1:0]         m_im_a,
    output logic [W-1:0]         m_re_q,
    output logic [W-1:0]         m_im_q,
    input  logic                 m_out_valid,
    input  logic [W-1:0]         m_re_res,
    input  logic [W-1:0]         m_im_res
);

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               transfer;
    int unsigned        sel;

    logic               m_in_valid_q, m_in_valid_d;
    logic [W-1:0]       m_re_a_q, m_re_a_d;
    logic [W-1:0]       m_im_a_q, m_im_a_d;
    logic [W-1:0]       m_re_q_q, m_re_q_d;
    logic [W-1:0]       m_im_q_q, m_im_q_d;

    tag_t               tag_q [MULT_LAT+1];
    tag_t               tag_d;
    tag_t               tag_out;
    logic               rsp_fire;

    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [W-1:0]       rsp_re_q, rsp_re_d;
    logic [W-1:0]       rsp_im_q, rsp_im_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_valid),
        .update_i    (transfer),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign req_ready = grant;
    assign transfer  = |(req_valid & grant);
    assign sel       = 32'(grant_idx);

    always_comb begin
        m_in_valid_d = transfer;
        m_re_a_d     = m_re_a_q;
        m_im_a_d     = m_im_a_q;
        m_re_q_d     = m_re_q_q;
        m_im_q_d     = m_im_q_q;
        if (transfer) begin
            m_re_a_d = req_re_a[sel*W +: W];
            m_im_a_d = req_im_a[sel*W +: W];
            m_re_q_d = req_re_q[sel*W +: W];
            m_im_q_d = req_im_q[sel*W +: W];
        end
    end

    // Stage k holds the tag of the op that was on the core input k cycles ago.
    always_comb begin
        tag_d.valid = transfer;
        tag_d.idx   = grant_idx;
        tag_out     = tag_q[MULT_LAT];
        rsp_fire    = m_out_valid & tag_out.valid;
        rsp_valid_d = '0;
        rsp_re_d    = rsp_re_q;
        rsp_im_d    = rsp_im_q;
        if (rsp_fire) begin
            rsp_valid_d = NUM_REQ'(1) << tag_out.idx;
            rsp_re_d    = m_re_res;
            rsp_im_d    = m_im_res;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_in_valid_q <= 1'b0;
            m_re_a_q     <= '0;
            m_im_a_q     <= '0;
            m_re_q_q     <= '0;
            m_im_q_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_re_q     <= '0;
            rsp_im_q     <= '0;
            for (int k = 0; k <= MULT_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            m_in_valid_q <= m_in_valid_d;
            m_re_a_q     <= m_re_a_d;
            m_im_a_q     <= m_im_a_d;
            m_re_q_q     <= m_re_q_d;
            m_im_q_q     <= m_im_q_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_re_q     <= rsp_re_d;
            rsp_im_q     <= rsp_im_d;
            tag_q[0]     <= tag_d;
            for (int k = 1; k <= MULT_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign m_in_valid = m_in_valid_q;
    assign m_re_a     = m_re_a_q;
    assign m_im_a     = m_im_a_q;
    assign m_re_q     = m_re_q_q;
    assign m_im_q     = m_im_q_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_re     = rsp_re_q;
    assign rsp_im     = rsp_im_q;

    // A core result without a matching in-flight tag (or vice versa) is a protocol error.
    tag_align_a: assert property (@(posedge clk) disable iff (reset)
        m_out_valid == tag_q[MULT_LAT].valid);

endmodule

// File: tb/tb_cmult_arbiter.sv
// Scoreboard bench for cmult_arbiter with a 3-cycle behavioural complex multiplier core.
module tb_cmult_arbiter;
    import cmplx_pkg::*;

    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned W        = 8;
    localparam int unsigned MULT_LAT = 3;

    typedef struct packed {
        logic [W-1:0] ra, ia, rq, iq, er, ei;
    } vec_t;

    typedef struct {
        int unsigned idx;
        cmplx_t      res;
        int          cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_re_a, req_im_a, req_re_q, req_im_q;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [W-1:0]         rsp_re, rsp_im;
    logic                 m_in_valid;
    logic [W-1:0]         m_re_a, m_im_a, m_re_q, m_im_q;
    logic                 m_out_valid;
    logic [W-1:0]         m_re_res, m_im_res;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_rsp    = 0;
    int run_len  = 0;
    int max_run  = 0;

    vec_t pend [NUM_REQ][$];
    exp_t exp_q [$];
    int   grant_log [$];
    exp_t e;

    cmult_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .W        (W),
        .MULT_LAT (MULT_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_re_a    (req_re_a),
        .req_im_a    (req_im_a),
        .req_re_q    (req_re_q),
        .req_im_q    (req_im_q),
        .rsp_valid   (rsp_valid),
        .rsp_re      (rsp_re),
        .rsp_im      (rsp_im),
        .m_in_valid  (m_in_valid),
        .m_re_a      (m_re_a),
        .m_im_a      (m_im_a),
        .m_re_q      (m_re_q),
        .m_im_q      (m_im_q),
        .m_out_valid (m_out_valid),
        .m_re_res    (m_re_res),
        .m_im_res    (m_im_res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural core: (a*q) truncated to W bits, MULT_LAT cycles, shares the reset.
    logic signed [15:0] ar, ai, qr, qi, pre, pim;
    logic [MULT_LAT-1:0] cv;
    logic [W-1:0] cre [MULT_LAT];
    logic [W-1:0] cim [MULT_LAT];
    always_comb begin
        ar  = 16'($signed(m_re_a));
        ai  = 16'($signed(m_im_a));
        qr  = 16'($signed(m_re_q));
        qi  = 16'($signed(m_im_q));
        pre = ar * qr - ai * qi;
        pim = ar * qi + ai * qr;
    end
    always @(posedge clk) begin
        if (reset) begin
            cv <= '0;
        end else begin
            cv     <= {cv[MULT_LAT-2:0], m_in_valid};
            cre[0] <= pre[W-1:0];
            cim[0] <= pim[W-1:0];
            for (int k = 1; k < MULT_LAT; k++) begin
                cre[k] <= cre[k-1];
                cim[k] <= cim[k-1];
            end
        end
    end
    assign m_out_valid = cv[MULT_LAT-1];
    assign m_re_res    = cre[MULT_LAT-1];
    assign m_im_res    = cim[MULT_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (m_in_valid === 1'b1) begin
            run_len = run_len + 1;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (rsp_valid !== '0) begin
            n_rsp = n_rsp + 1;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_route", 32'(rsp_valid), 32'(1) << e.idx);
                chk("rsp_re", 32'(rsp_re), 32'(e.res.re) & 32'hFF);
                chk("rsp_im", 32'(rsp_im), 32'(e.res.im) & 32'hFF);
                chk("rsp_latency", 32'(cyc - e.cyc), 32'(MULT_LAT + 2));
            end
        end
    end

    task automatic add(input int i, input int ra, input int ia, input int rq, input int iq,
                       input int er, input int ei);
        vec_t v;
        v.ra = W'(ra); v.ia = W'(ia); v.rq = W'(rq); v.iq = W'(iq);
        v.er = W'(er); v.ei = W'(ei);
        pend[i].push_back(v);
    endtask

    // Present queued ops (valid held until accepted); record accepts and expectations.
    task automatic drain(input int budget, output int used);
        exp_t x;
        used = 0;
        while (pend[0].size() + pend[1].size() > 0) begin
            if (used >= budget) begin
                chk("drain_timeout", 32'(used), 32'(budget - 1));
                break;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = pend[i].size() > 0;
                if (pend[i].size() > 0) begin
                    req_re_a[i*W +: W] = pend[i][0].ra;
                    req_im_a[i*W +: W] = pend[i][0].ia;
                    req_re_q[i*W +: W] = pend[i][0].rq;
                    req_im_q[i*W +: W] = pend[i][0].iq;
                end
            end
            @(negedge clk);
            chk("no_stray_grant", 32'(req_ready & ~req_valid), 32'd0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    x.idx    = i;
                    x.res.re = pend[i][0].er;
                    x.res.im = pend[i][0].ei;
                    x.cyc    = cyc;
                    exp_q.push_back(x);
                    grant_log.push_back(i);
                    void'(pend[i].pop_front());
                end
            end
            @(posedge clk);
            #1;
            used++;
        end
        req_valid = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rsp_outstanding", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int used;
        int rsp_before;
        reset     = 1'b1;
        req_valid = '1;
        req_re_a  = '0; req_im_a = '0; req_re_q = '0; req_im_q = '0;

        // 1: reset held with every requester valid
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_m_in_valid", 32'(m_in_valid), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        chk("rst_m_operands", {m_re_a, m_im_a, m_re_q, m_im_q}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_re, rsp_im}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        reset     = 1'b0;

        // 2: single op (3+4j)(1+2j) = -5+10j
        add(0, 3, 4, 1, 2, 8'hFB, 8'h0A);
        drain(10, used);
        chk("single_accept_cycles", 32'(used), 32'd1);
        wait_idle(20);

        // 3: contention right after reset, requester 0 first
        reset_pulse();
        grant_log.delete();
        add(0, 0, 1, 2, 0, 8'h00, 8'h02);
        add(1, 2, 3, 4, -1, 8'h0B, 8'h0A);
        drain(10, used);
        chk("contend_cycles", 32'(used), 32'd2);
        chk("contend_first", 32'(grant_log[0]), 32'd0);
        chk("contend_second", 32'(grant_log[1]), 32'd1);
        wait_idle(20);

        // 4: saturated load, grants alternate and the core is fed every cycle
        grant_log.delete();
        max_run = 0;
        add(0, 1, 1, 1, 1, 8'h00, 8'h02);
        add(0, 2, 0, 3, 0, 8'h06, 8'h00);
        add(0, -1, 0, 5, 0, 8'hFB, 8'h00);
        add(0, 4, 4, 4, -4, 8'h20, 8'h00);
        add(1, 0, 2, 0, 3, 8'hFA, 8'h00);
        add(1, 1, 2, 3, 4, 8'hFB, 8'h0A);
        add(1, 10, 0, 10, 0, 8'h64, 8'h00);
        add(1, 12, 0, 11, 0, 8'h84, 8'h00);
        drain(20, used);
        chk("sat_cycles", 32'(used), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("sat_grant_order", 32'(grant_log[k]), 32'(k % 2));
        end
        wait_idle(20);
        chk("sat_m_in_valid_run", 32'(max_run), 32'd8);

        // 5: lone requester 1, back-to-back accepts
        grant_log.delete();
        for (int k = 1; k <= 4; k++) add(1, 1, 0, k, 0, k, 0);
        drain(10, used);
        chk("b2b_cycles", 32'(used), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("b2b_grant", 32'(grant_log[k]), 32'd1);
        end
        wait_idle(20);

        // 6: reset while two ops are in flight; neither may come back
        add(0, 5, 0, 5, 0, 8'h19, 8'h00);
        add(1, 1, 1, 2, 0, 8'h02, 8'h02);
        drain(10, used);
        chk("flight_cycles", 32'(used), 32'd2);
        rsp_before = n_rsp;
        reset_pulse();
        @(negedge clk);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("flight_dropped", 32'(n_rsp - rsp_before), 32'd0);
        add(0, 3, -2, 2, 1, 8'h08, 8'hFF);
        drain(10, used);
        wait_idle(20);
        chk("post_rst_rsp_count", 32'(n_rsp - rsp_before), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
